// File: rtl/contador_pkg.sv
// Shared types for the up/down button counter family: FSM state and
// button-owner encodings, plus a helper for sizing timer registers.
package contador_pkg;

  // Control FSM states, shared with display and counter siblings.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCK   = 2'd3
  } ctrl_state_e;

  // Which button owns the current press; the value doubles as step direction.
  typedef enum logic {
    OWN_DN = 1'b0,
    OWN_UP = 1'b1
  } owner_e;

  // Bit positions of the two buttons inside packed button vectors.
  localparam int unsigned BTN_UP = 0;
  localparam int unsigned BTN_DN = 1;
  localparam int unsigned N_BTN  = 2;

  // Number of bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    int unsigned bits;
    bits = 1;
    while ((max_val >> bits) != 0) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Button conditioner: two-flop synchronizer followed by a debouncer that
// only accepts a new level after DEB_CYCLES consecutive differing samples.
module antirrebote
  import contador_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_lvl
);

  localparam int unsigned CW = cnt_bits(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync1_d;
  logic          sync2_q;
  logic          sync2_d;
  logic          lvl_q;
  logic          lvl_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Synchronizer shift plus debounce run-length counter.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    cnt_d   = '0;
    if (sync2_q != lvl_q) begin
      // Any matching sample in between resets the run, so only an
      // uninterrupted run of differing samples flips the level.
      if (cnt_q == DEB_LAST) begin
        lvl_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers for synchronizer, level and run counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_lvl = lvl_q;

endmodule

// File: rtl/contador_ctrl.sv
// Up/down counter driven by two bouncing buttons: single step on press,
// auto-repeat after a hold delay, and a lock-out while both are pressed.
module contador_ctrl
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned REP_CYCLES  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             locked
);

  localparam int unsigned HW = cnt_bits(HOLD_CYCLES - 1);
  localparam int unsigned RW = cnt_bits(REP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REP_CYCLES - 1);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_lvl;
  logic [N_BTN-1:0] lvl_prev_q;
  logic [N_BTN-1:0] lvl_prev_d;
  logic [N_BTN-1:0] btn_rise;

  ctrl_state_e      state_q;
  ctrl_state_e      state_d;
  owner_e           owner_q;
  owner_e           owner_d;
  logic [HW-1:0]    hold_cnt_q;
  logic [HW-1:0]    hold_cnt_d;
  logic [RW-1:0]    rep_cnt_q;
  logic [RW-1:0]    rep_cnt_d;
  logic             step_q;
  logic             step_d;
  logic             dir_q;
  logic             dir_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  logic             own_held;
  logic             other_held;

  assign btn_raw[BTN_UP] = btn_up;
  assign btn_raw[BTN_DN] = btn_dn;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      antirrebote #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_antirrebote (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw[gi]),
        .btn_lvl (btn_lvl[gi])
      );
    end
  endgenerate

  // Edge detection on the debounced levels.
  always_comb begin
    lvl_prev_d = btn_lvl;
    btn_rise   = btn_lvl & ~lvl_prev_q;
  end

  // Held status of the press owner and of the opposing button.
  always_comb begin
    own_held   = 1'b0;
    other_held = 1'b0;
    if (owner_q == OWN_UP) begin
      own_held   = btn_lvl[BTN_UP];
      other_held = btn_lvl[BTN_DN];
    end else begin
      own_held   = btn_lvl[BTN_DN];
      other_held = btn_lvl[BTN_UP];
    end
  end

  // Next-state, timers and step request for the control FSM.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_lvl[BTN_UP] && btn_lvl[BTN_DN]) begin
          state_d = ST_LOCK;
        end else if (btn_rise[BTN_UP] && !btn_lvl[BTN_DN]) begin
          step_d     = 1'b1;
          dir_d      = 1'b1;
          owner_d    = OWN_UP;
          hold_cnt_d = '0;
          state_d    = ST_HOLD;
        end else if (btn_rise[BTN_DN] && !btn_lvl[BTN_UP]) begin
          step_d     = 1'b1;
          dir_d      = 1'b0;
          owner_d    = OWN_DN;
          hold_cnt_d = '0;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Lock is tested before release so IDLE is only ever entered
        // with both buttons low.
        if (other_held) begin
          state_d = ST_LOCK;
        end else if (!own_held) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          step_d    = 1'b1;
          dir_d     = (owner_q == OWN_UP);
          rep_cnt_d = '0;
          state_d   = ST_REPEAT;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_REPEAT: begin
        if (other_held) begin
          state_d = ST_LOCK;
        end else if (!own_held) begin
          state_d = ST_IDLE;
        end else if (rep_cnt_q == REP_LAST) begin
          step_d    = 1'b1;
          dir_d     = (owner_q == OWN_UP);
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
      end
      ST_LOCK: begin
        if (!btn_lvl[BTN_UP] && !btn_lvl[BTN_DN]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counter applies the registered step one cycle later; clear wins.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (step_q) begin
      if (dir_q) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  // State registers for FSM, timers, outputs and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_UP;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      count_q    <= '0;
      lvl_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      count_q    <= count_d;
      lvl_prev_q <= lvl_prev_d;
    end
  end

  assign count  = count_q;
  assign step   = step_q;
  assign dir    = dir_q;
  assign locked = (state_q == ST_LOCK);

endmodule

// File: tb/tb_contador_ctrl.sv
// Bench for contador_ctrl: directed table, hand-written corner sequences
// and randomized buttons, all checked each cycle against a press-age model.
module tb_contador_ctrl;

  localparam int W    = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 16;
  localparam int REP  = 8;
  localparam int MOD  = 1 << W;

  localparam int M_IDLE    = 0;
  localparam int M_PRESSED = 1;
  localparam int M_LOCK    = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_up;
  logic         btn_dn;
  logic         clr;
  logic [W-1:0] count;
  logic         step;
  logic         dir;
  logic         locked;

  always #5 clk = ~clk;

  contador_ctrl #(
    .WIDTH       (W),
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD),
    .REP_CYCLES  (REP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .clr    (clr),
    .count  (count),
    .step   (step),
    .dir    (dir),
    .locked (locked)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int steps_seen = 0;

  // Reference model: per-button pipeline/run-length, and a press age that
  // counts cycles since the first step of the current press.
  int m_s1 [2];
  int m_s2 [2];
  int m_lvl[2];
  int m_run[2];
  int m_mode;
  int m_owner;   // 0 = up button, 1 = down button
  int m_age;
  int m_count;
  int m_step;
  int m_dir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int raw[2];
    int nstep;
    int ndir;
    raw[0] = int'(btn_up);
    raw[1] = int'(btn_dn);
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_run[b] = 0;
      end
      m_mode = M_IDLE; m_owner = 0; m_age = 0;
      m_count = 0; m_step = 0; m_dir = 0;
      return;
    end
    nstep = 0;
    ndir  = m_dir;
    case (m_mode)
      M_IDLE: begin
        if (m_lvl[0] != 0 && m_lvl[1] != 0) begin
          m_mode = M_LOCK;
        end else if (m_lvl[0] != 0 || m_lvl[1] != 0) begin
          m_owner = (m_lvl[0] != 0) ? 0 : 1;
          m_mode  = M_PRESSED;
          m_age   = 0;
          nstep   = 1;
          ndir    = (m_owner == 0) ? 1 : 0;
        end
      end
      M_PRESSED: begin
        if (m_lvl[1 - m_owner] != 0) begin
          m_mode = M_LOCK;
        end else if (m_lvl[m_owner] == 0) begin
          m_mode = M_IDLE;
        end else begin
          m_age++;
          if (m_age >= HOLD && ((m_age - HOLD) % REP) == 0) begin
            nstep = 1;
            ndir  = (m_owner == 0) ? 1 : 0;
          end
        end
      end
      default: begin
        if (m_lvl[0] == 0 && m_lvl[1] == 0) m_mode = M_IDLE;
      end
    endcase
    if (clr) m_count = 0;
    else if (m_step != 0) m_count = (m_count + ((m_dir != 0) ? 1 : MOD - 1)) % MOD;
    m_step = nstep;
    m_dir  = ndir;
    for (int b = 0; b < 2; b++) begin
      if (m_s2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_lvl[b] = m_s2[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endtask

  // One clock: advance the model, then compare all outputs 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk("model_count",  32'(count),  32'(m_count));
    chk("model_step",   32'(step),   32'(m_step));
    chk("model_dir",    32'(dir),    32'(m_dir));
    chk("model_locked", 32'(locked), 32'(m_mode == M_LOCK));
    if (step === 1'b1) steps_seen++;
  endtask

  // Ticks until a step is seen; returns tick count or -1 if the budget runs out.
  task automatic wait_step(input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (step === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  typedef struct {
    bit up;
    bit dn;
    int cycles;
    int steps;
    int cnt;
    bit dir;
    bit lck;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int n;
    int offs[$];
    int exp_off[6];
    int up_left, dn_left, up_bn, dn_bn;
    bit up_tgt, dn_tgt;

    vecs = '{
      '{0, 0,  5, 0, 0, 0, 0},   // idle after reset
      '{1, 0, 12, 1, 1, 1, 0},   // up press: 0 -> 1
      '{0, 0, 12, 0, 1, 1, 0},
      '{0, 1, 12, 1, 0, 0, 0},   // down press: 1 -> 0
      '{0, 0, 12, 0, 0, 0, 0},
      '{0, 1, 12, 1, 3, 0, 0},   // down press wraps 0 -> 3
      '{0, 0, 12, 0, 3, 0, 0},
      '{1, 1, 12, 0, 3, 0, 1},   // simultaneous press locks
      '{1, 0, 12, 0, 3, 0, 1},   // one still held: stays locked
      '{0, 0, 12, 0, 3, 0, 0},   // both released: unlock
      '{1, 0, 32, 3, 2, 1, 0},   // hold into repeat: 3 steps, 3 -> 2 via wrap
      '{1, 1, 12, 0, 2, 1, 1},   // down during repeat: lock beats due step
      '{0, 1, 12, 0, 2, 1, 1},   // release up only: still locked
      '{0, 0, 12, 0, 2, 1, 0}    // release down: unlock
    };
    exp_off = '{0, 16, 24, 32, 40, 48};

    rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0; clr = 1'b0;
    repeat (3) tick();
    chk("reset_count",  32'(count),  32'd0);
    chk("reset_step",   32'(step),   32'd0);
    chk("reset_dir",    32'(dir),    32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    rst = 1'b0;

    // Table-driven directed vectors.
    for (int v = 0; v < 14; v++) begin
      btn_up = vecs[v].up;
      btn_dn = vecs[v].dn;
      steps_seen = 0;
      repeat (vecs[v].cycles) tick();
      chk($sformatf("vec%0d_steps", v),  32'(steps_seen), 32'(vecs[v].steps));
      chk($sformatf("vec%0d_count", v),  32'(count),      32'(vecs[v].cnt));
      chk($sformatf("vec%0d_dir", v),    32'(dir),        32'(vecs[v].dir));
      chk($sformatf("vec%0d_locked", v), 32'(locked),     32'(vecs[v].lck));
    end

    // Bouncing press: exactly one up step, 2 -> 3.
    steps_seen = 0;
    btn_up = 1'b1; tick();
    btn_up = 1'b0; tick();
    btn_up = 1'b1; tick();
    repeat (10) tick();
    chk("bounce_steps", 32'(steps_seen), 32'd1);
    chk("bounce_count", 32'(count),      32'd3);
    chk("bounce_dir",   32'(dir),        32'd1);
    btn_up = 1'b0;
    repeat (12) tick();

    // Clear, then a long hold: step offsets 0,16,24,32,40,48 and wrap to 2.
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_count", 32'(count), 32'd0);
    for (int k = 1; k <= 72; k++) begin
      btn_up = (k <= 52);
      tick();
      if (step === 1'b1) offs.push_back(k);
    end
    btn_up = 1'b0;
    chk("hold_nsteps", 32'(offs.size()), 32'd6);
    if (offs.size() > 0) chk("press_latency", 32'(offs[0]), 32'(3 + DEB));
    for (int i = 1; i < 6 && i < offs.size(); i++)
      chk($sformatf("hold_offset%0d", i), 32'(offs[i] - offs[0]), 32'(exp_off[i]));
    chk("hold_count", 32'(count), 32'd2);

    // Clear coincident with a count update from 2; FSM stays in HOLD.
    btn_up = 1'b1;
    wait_step(20, n);
    chk("clrstep_latency", 32'(n), 32'(3 + DEB));
    chk("clrstep_pre_count", 32'(count), 32'd2);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clrstep_count", 32'(count), 32'd0);
    chk("clrstep_step_cleared", 32'(step), 32'd0);
    wait_step(30, n);
    chk("clrstep_hold_step", 32'(n), 32'(HOLD - 1));
    tick();
    chk("clrstep_after_count", 32'(count), 32'd1);
    btn_up = 1'b0;
    repeat (15) tick();

    // Reset in REPEAT: outputs cleared, held button re-accepted as a new press.
    btn_up = 1'b1;
    wait_step(20, n);
    repeat (20) tick();
    rst = 1'b1; tick();
    chk("rst_count",  32'(count),  32'd0);
    chk("rst_step",   32'(step),   32'd0);
    chk("rst_dir",    32'(dir),    32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    rst = 1'b0;
    wait_step(30, n);
    chk("rst_repress_latency", 32'(n), 32'(3 + DEB));
    btn_up = 1'b0;
    repeat (15) tick();

    // Randomized buttons with bounce, occasional clr and rst.
    up_left = 0; dn_left = 0; up_bn = 0; dn_bn = 0;
    up_tgt = 1'b0; dn_tgt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (up_left == 0) begin
        up_tgt  = ($urandom % 2) == 0;
        up_left = $urandom_range(2, 60);
        up_bn   = $urandom_range(0, 5);
      end
      if (dn_left == 0) begin
        dn_tgt  = ($urandom % 3) == 0;
        dn_left = $urandom_range(2, 40);
        dn_bn   = $urandom_range(0, 5);
      end
      btn_up = (up_bn > 0) ? ($urandom % 2 == 0) : up_tgt;
      btn_dn = (dn_bn > 0) ? ($urandom % 2 == 0) : dn_tgt;
      if (up_bn > 0) up_bn--;
      if (dn_bn > 0) dn_bn--;
      up_left--;
      dn_left--;
      clr = ($urandom % 40) == 0;
      rst = ($urandom % 500) == 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/contador_ctrl.md
CONTADOR_CTRL -- requirements
Module: contador_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the counter width in bits.
REQ-002 The block SHALL have parameter DEB_CYCLES, default 4, giving the consecutive stable samples needed to accept a button level change.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 16, giving the cycles a button is held after its first step before auto-repeat starts.
REQ-004 The block SHALL have parameter REP_CYCLES, default 8, giving the auto-repeat step period in cycles.
REQ-005 The block SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port btn_up, input, 1 bit: raw asynchronous, bouncing up button, active-high.
REQ-008 The block SHALL have port btn_dn, input, 1 bit: raw asynchronous, bouncing down button, active-high.
REQ-009 The block SHALL have port clr, input, 1 bit: synchronous clear of the count.
REQ-010 The block SHALL have port count, output, WIDTH bits: registered counter value.
REQ-011 The block SHALL have port step, output, 1 bit: registered one-cycle pulse on each accepted step.
REQ-012 The block SHALL have port dir, output, 1 bit: direction of the last step (1 up, 0 down).
REQ-013 The block SHALL have port locked, output, 1 bit: high while in LOCK state.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer and then a debouncer; the debounced level changes only after DEB_CYCLES consecutive synchronized samples differ from the current level, and any intermediate mismatch restarts the count.
REQ-015 The FSM SHALL have states IDLE, HOLD, REPEAT and LOCK, plus an owner register (UP/DN) valid in HOLD and REPEAT.
REQ-016 IDLE: on a debounced rising edge of exactly one button, with the other button debounced-low, the FSM SHALL issue one step in that button's direction, set owner, clear the hold counter and go to HOLD.
REQ-017 IDLE: if both debounced levels are high in the same cycle, the FSM SHALL go to LOCK with no step.
REQ-018 HOLD: on owner release the FSM SHALL go to IDLE; when the non-owner goes high it SHALL go to LOCK; when the hold counter reaches HOLD_CYCLES-1 it SHALL issue a step, clear the repeat counter and go to REPEAT.
REQ-019 REPEAT: the FSM SHALL issue a step every REP_CYCLES cycles while the owner is held, go to IDLE on owner release, and go to LOCK when the non-owner goes high.
REQ-020 LOCK: the FSM SHALL stay in LOCK, with no steps, until both debounced levels are low, then go to IDLE.
REQ-021 Release and lock checks SHALL take precedence over step issue in the same cycle.
REQ-022 On a step, step SHALL be high for exactly one cycle, dir SHALL be updated in the same cycle, and count SHALL show the new value in the following cycle.
REQ-023 Counting SHALL wrap modulo 2^WIDTH: all-ones +1 gives 0, and 0 -1 gives all-ones.
REQ-024 clr SHALL set count to 0 on the next edge, override a coincident step update, and leave the FSM, step and dir unaffected.
REQ-025 For a clean press, step SHALL assert exactly 3+DEB_CYCLES edges after the first edge sampling btn high.

Reset
REQ-026 While rst is high, count, step, dir, locked, the synchronizers, debounced levels and all counters SHALL be 0, and the FSM SHALL be IDLE with owner UP.
REQ-027 After reset, a button already held SHALL be treated as a new press once debounced.
REQ-028 Reset asserted mid-HOLD or mid-REPEAT SHALL abort with no further step.

Structure
REQ-029 State encodings and owner encodings SHALL live in shared package contador_pkg, so that sibling display and counter blocks reuse them.
REQ-030 The debouncer SHALL be sub-module antirrebote (synchronizer plus debounce, parameter DEB_CYCLES), instantiated once per button.
REQ-031 The FSM, timers and counter SHALL be in contador_ctrl.

Verification
REQ-032 Defaults: btn_up bounces 0/1 for 3 cycles, then holds 1 for 10 cycles -> exactly one step with dir=1, and count 0->1.
REQ-033 Defaults: btn_up held for 60 cycles from count=0 -> steps at the first step, +16, +24, +32, +40, +48 relative to the first step (six steps), and count ends at 2 via wrap 3->0.
REQ-034 Defaults: count=0, single btn_dn press -> count=3, dir=0.
REQ-035 Defaults: btn_up held in REPEAT, btn_dn pressed -> locked=1 with no steps; release only btn_up -> still locked; release btn_dn -> IDLE and locked=0.
REQ-036 clr asserted in the same cycle as a step from count=2 -> count=0, step=1 for one cycle, and the FSM stays in HOLD.
REQ-037 rst pulsed during REPEAT -> all outputs 0 the next cycle; with btn_up still held, a new step occurs 3+4 cycles after rst drops.
